hs_cdc_pulse_collector: RTL and testbench



---
 rtl/hs_ifr_misc_typedefs_pkg.sv | 19 +
 rtl/hs_cdc_pulse_collector_ch.sv | 85 ++++++++
 rtl/hs_cdc_syncer.sv | 34 +++
 rtl/hs_cdc_pulse_collector.sv | 140 ++++++++++++++
 tb/tb_hs_cdc_pulse_collector.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hs_ifr_misc_typedefs_pkg.sv
// Shared typedefs and limits for the hs_cdc family of blocks.
// Optional feature macro used by importers: HS_CDC_PULSE_COLLECTOR_OVF_STICKY_EN.
package hs_ifr_misc_typedefs_pkg;

   localparam int unsigned HS_CDC_MAX_CH     = 32;
   localparam int unsigned HS_CDC_MIN_SYNC   = 2;
   localparam int unsigned HS_CDC_MAX_SYNC   = 32;
   localparam int unsigned HS_CDC_MAX_CNT_W  = 8;

   typedef enum logic {
      PC_IDLE  = 1'b0,
      PC_OFFER = 1'b1
   } hs_cdc_pc_state_e;

   function automatic int unsigned hs_clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hs_cdc_pulse_collector_ch.sv
// One collector channel: edge history, saturating pending counter, optional sticky overflow.
// Sticky overflow is built only with HS_CDC_PULSE_COLLECTOR_OVF_STICKY_EN defined.
module hs_cdc_pulse_collector_ch
   import hs_ifr_misc_typedefs_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic                 synced,
   input  logic                 dec,
   input  logic                 ovf_clr,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic [CNT_WIDTH-1:0] cnt_nxt,
   output logic                 ovf
);

   typedef logic [CNT_WIDTH-1:0] cnt_t;
   localparam cnt_t CNT_MAX = '1;

   logic hist_q;
   logic hist_d;
   logic evt;
   logic drop;
   cnt_t cnt_q;
   cnt_t cnt_d;

   if (CNT_WIDTH < 1 || CNT_WIDTH > HS_CDC_MAX_CNT_W) begin : g_bad_cnt
      $error("hs_cdc_pulse_collector_ch: CNT_WIDTH out of range");
   end

   always_comb begin
      hist_d = synced;
      evt    = synced ^ hist_q;
      drop   = 1'b0;
      cnt_d  = cnt_q;
      if (evt && !dec) begin
         if (cnt_q == CNT_MAX) begin
            drop = 1'b1;
         end else begin
            cnt_d = cnt_q + cnt_t'(1);
         end
      end else if (!evt && dec) begin
         cnt_d = cnt_q - cnt_t'(1);
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         hist_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_d;
         cnt_q  <= cnt_d;
      end
   end

   assign cnt     = cnt_q;
   assign cnt_nxt = cnt_d;

`ifdef HS_CDC_PULSE_COLLECTOR_OVF_STICKY_EN
   logic ovf_q;
   logic ovf_d;

   // A drop in the same cycle as a clear keeps the flag set.
   always_comb begin
      ovf_d = drop | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   logic unused_ovf_sink;
   assign unused_ovf_sink = ovf_clr | drop;
   assign ovf             = 1'b0;
`endif

endmodule

// File: rtl/hs_cdc_syncer.sv
// Single-bit multi-flop synchronizer into clk; all stages reset to 0.
module hs_cdc_syncer
   import hs_ifr_misc_typedefs_pkg::*;
#(
   parameter int unsigned SYNC_STAGE = 2
) (
   input  logic clk,
   input  logic areset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGE-1:0] sync_q;
   logic [SYNC_STAGE-1:0] sync_d;

   if (SYNC_STAGE < HS_CDC_MIN_SYNC || SYNC_STAGE > HS_CDC_MAX_SYNC) begin : g_bad_sync
      $error("hs_cdc_syncer: SYNC_STAGE out of range");
   end

   always_comb begin
      sync_d = {sync_q[SYNC_STAGE-2:0], d};
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGE-1];

endmodule

// File: rtl/hs_cdc_pulse_collector.sv
// Multi-channel toggle collector: per-channel sync + pending counters, drained round-robin.
// Sticky overflow flags need HS_CDC_PULSE_COLLECTOR_OVF_STICKY_EN; otherwise ovf reads 0.
module hs_cdc_pulse_collector
   import hs_ifr_misc_typedefs_pkg::*;
#(
   parameter  int unsigned CH_NUM     = 4,
   parameter  int unsigned SYNC_STAGE = 2,
   parameter  int unsigned CNT_WIDTH  = 3,
   localparam int unsigned CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic              clk,
   input  logic              areset,
   input  logic [CH_NUM-1:0] tgl_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH_W-1:0]   out_ch,
   output logic [CH_NUM-1:0] ovf,
   input  logic [CH_NUM-1:0] ovf_clr
);

   typedef logic [CNT_WIDTH-1:0] cnt_t;
   typedef logic [CH_W-1:0]      ch_t;

   logic [CH_NUM-1:0] synced;
   logic [CH_NUM-1:0] dec;
   logic [CH_NUM-1:0] pend_now;
   logic [CH_NUM-1:0] pend_nxt;
   cnt_t              cnt     [CH_NUM];
   cnt_t              cnt_nxt [CH_NUM];

   hs_cdc_pc_state_e state_q;
   hs_cdc_pc_state_e state_d;
   ch_t              out_ch_q;
   ch_t              out_ch_d;
   ch_t              ptr_q;
   ch_t              ptr_d;
   logic             hs;

   if (CH_NUM < 1 || CH_NUM > HS_CDC_MAX_CH) begin : g_bad_ch
      $error("hs_cdc_pulse_collector: CH_NUM out of range");
   end

   function automatic ch_t ch_inc(input ch_t c);
      if (32'(c) >= CH_NUM - 1) begin
         return '0;
      end
      return c + ch_t'(1);
   endfunction

   function automatic ch_t rr_pick(input logic [CH_NUM-1:0] mask, input ch_t start);
      int unsigned idx;
      logic        found;
      ch_t         pick;
      pick  = start;
      found = 1'b0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         idx = (32'(start) + i) % CH_NUM;
         if (!found && mask[ch_t'(idx)]) begin
            pick  = ch_t'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign hs = (state_q == PC_OFFER) && out_ready;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      hs_cdc_syncer #(
         .SYNC_STAGE (SYNC_STAGE)
      ) u_sync (
         .clk    (clk),
         .areset (areset),
         .d      (tgl_in[g]),
         .q      (synced[g])
      );

      hs_cdc_pulse_collector_ch #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_ch (
         .clk     (clk),
         .areset  (areset),
         .synced  (synced[g]),
         .dec     (dec[g]),
         .ovf_clr (ovf_clr[g]),
         .cnt     (cnt[g]),
         .cnt_nxt (cnt_nxt[g]),
         .ovf     (ovf[g])
      );

      assign dec[g]      = hs && (out_ch_q == ch_t'(g));
      assign pend_now[g] = (cnt[g] != '0);
      assign pend_nxt[g] = (cnt_nxt[g] != '0);
   end

   // On a handshake the next grant is chosen from the post-update counts so that
   // an event landing this cycle keeps the stream running without an IDLE bubble.
   always_comb begin
      state_d  = state_q;
      out_ch_d = out_ch_q;
      ptr_d    = ptr_q;
      case (state_q)
         PC_IDLE: begin
            if (|pend_now) begin
               out_ch_d = rr_pick(pend_now, ch_inc(ptr_q));
               state_d  = PC_OFFER;
            end
         end
         PC_OFFER: begin
            if (out_ready) begin
               ptr_d = out_ch_q;
               if (|pend_nxt) begin
                  out_ch_d = rr_pick(pend_nxt, ch_inc(out_ch_q));
               end else begin
                  state_d = PC_IDLE;
               end
            end
         end
         default: begin
            state_d = PC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q  <= PC_IDLE;
         out_ch_q <= '0;
         ptr_q    <= '0;
      end else begin
         state_q  <= state_d;
         out_ch_q <= out_ch_d;
         ptr_q    <= ptr_d;
      end
   end

   assign out_valid = (state_q == PC_OFFER);
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_hs_cdc_pulse_collector.sv
// Scoreboard bench for hs_cdc_pulse_collector: per-channel expected-event queues,
// directed scenarios followed by randomized toggles and backpressure.
module tb_hs_cdc_pulse_collector;

   localparam int unsigned CH_NUM     = 4;
   localparam int unsigned SYNC_STAGE = 2;
   localparam int unsigned CNT_WIDTH  = 3;
   localparam int unsigned CH_W       = 2;
   localparam int unsigned CNT_MAX    = (1 << CNT_WIDTH) - 1;

   logic              clk       = 1'b0;
   logic              areset    = 1'b1;
   logic [CH_NUM-1:0] tgl_in    = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [CH_W-1:0]   out_ch;
   logic [CH_NUM-1:0] ovf;
   logic [CH_NUM-1:0] ovf_clr   = '0;

   int                checks = 0;
   int                errors = 0;
   int                cyc    = 0;
   int                exp_q [CH_NUM][$];
   int                grants [CH_NUM];
   logic [CH_NUM-1:0] model_ovf = '0;

   hs_cdc_pulse_collector #(
      .CH_NUM     (CH_NUM),
      .SYNC_STAGE (SYNC_STAGE),
      .CNT_WIDTH  (CNT_WIDTH)
   ) dut (
      .clk       (clk),
      .areset    (areset),
      .tgl_in    (tgl_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model of one event per toggled bit: buffered while below the counter limit, else lost.
   task automatic apply(input logic [CH_NUM-1:0] m);
      for (int c = 0; c < CH_NUM; c++) begin
         if (m[c]) begin
            tgl_in[c] = ~tgl_in[c];
            if (exp_q[c].size() < CNT_MAX) exp_q[c].push_back(cyc);
            else model_ovf[c] = 1'b1;
         end
      end
   endtask

   task automatic pulse(input logic [CH_NUM-1:0] m);
      @(posedge clk);
      #1;
      apply(m);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int c = 0; c < CH_NUM; c++) begin
         exp_q[c].delete();
         grants[c] = 0;
      end
      model_ovf = '0;
   endtask

   task automatic reset_release();
      repeat (3) @(posedge clk);
      #1;
      areset = 1'b0;
   endtask

   task automatic wait_valid(input int max, output int at, output bit ok);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_drain(input int max, output bit ok);
      int total;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         total = 0;
         for (int c = 0; c < CH_NUM; c++) total += exp_q[c].size();
         if (total == 0 && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Monitor: every handshake must match a buffered event, respect the sync latency
   // and not skip an older pending channel that lies earlier in round-robin order.
   initial begin
      logic            prev_valid;
      logic            prev_ready;
      logic [CH_W-1:0] prev_ch;
      logic [CH_W-1:0] last_grant;
      int              offer_edge;
      int              c;
      int              k;
      int              j;
      logic            viol;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_ch    = '0;
      last_grant = '0;
      offer_edge = 0;
      forever begin
         @(negedge clk);
         if (areset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            last_grant = '0;
         end else begin
            if (prev_valid && !prev_ready) begin
               check("hold_valid", 32'(out_valid), 32'd1);
               check("hold_ch", 32'(out_ch), 32'(prev_ch));
            end
            if (out_valid && (!prev_valid || prev_ready)) offer_edge = cyc;
            if (out_valid && out_ready) begin
               c = int'(out_ch);
               grants[c]++;
               checks++;
               if (exp_q[c].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_event: got channel %0d, expected no event (cycle %0d)", c, cyc);
               end else begin
                  k = exp_q[c].pop_front();
                  check("latency_min", 32'(offer_edge >= k + int'(SYNC_STAGE) + 1), 32'd1);
                  viol = 1'b0;
                  j = (int'(last_grant) + 1) % CH_NUM;
                  while (j != c) begin
                     if (exp_q[j].size() > 0 && exp_q[j][0] + int'(SYNC_STAGE) + 1 <= offer_edge - 1)
                        viol = 1'b1;
                     j = (j + 1) % CH_NUM;
                  end
                  check("rr_order", 32'(viol), 32'd0);
               end
               last_grant = out_ch;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_ch    = out_ch;
         end
      end
   end

   initial begin
      int              k0;
      int              at;
      bit              ok;
      logic            cont;
      logic            exp_ovf;
      int              vcnt;
      logic [CH_NUM-1:0] m;

      clear_model();
      #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ch", 32'(out_ch), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      reset_release();

      // Single event, exact latency, one-cycle offer.
      out_ready = 1'b1;
      pulse(4'b0100);
      k0 = cyc;
      wait_valid(12, at, ok);
      check("single_seen", 32'(ok), 32'd1);
      check("single_latency", 32'(at - k0), 32'(SYNC_STAGE + 2));
      check("single_ch", 32'(out_ch), 32'd2);
      @(negedge clk);
      check("single_one_cycle", 32'(out_valid), 32'd0);
      check("single_drained", 32'(exp_q[2].size()), 32'd0);

      // Backpressure: three buffered events on channel 1.
      idle(2);
      out_ready = 1'b0;
      pulse(4'b0010);
      idle(4);
      pulse(4'b0010);
      idle(4);
      pulse(4'b0010);
      idle(6);
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_ch", 32'(out_ch), 32'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_drain_valid", 32'(out_valid), 32'd1);
         check("bp_drain_ch", 32'(out_ch), 32'd1);
      end
      @(negedge clk);
      check("bp_done", 32'(out_valid), 32'd0);

      // Round-robin from a freshly reset pointer.
      #1;
      areset = 1'b1;
      tgl_in = '0;
      clear_model();
      reset_release();
      out_ready = 1'b1;
      pulse(4'b1111);
      wait_valid(12, at, ok);
      check("rr_seen", 32'(ok), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check("rr_seq_valid", 32'(out_valid), 32'd1);
         check("rr_seq_ch", 32'(out_ch), 32'((i + 1) % CH_NUM));
      end
      @(negedge clk);
      check("rr_done", 32'(out_valid), 32'd0);

      // Event every cycle on channel 0 with a ready sink keeps out_valid high.
      idle(2);
      cont = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pulse(4'b0001);
         if (i >= SYNC_STAGE + 2 && !out_valid) cont = 1'b0;
      end
      check("incdec_continuous", 32'(cont), 32'd1);
      wait_drain(30, ok);
      check("incdec_drained", 32'(ok), 32'd1);

      // Saturation on channel 3.
      out_ready = 1'b0;
      for (int i = 0; i < CNT_MAX + 2; i++) begin
         pulse(4'b1000);
         idle(1);
      end
      idle(6);
`ifdef HS_CDC_PULSE_COLLECTOR_OVF_STICKY_EN
      exp_ovf = model_ovf[3];
`else
      exp_ovf = 1'b0;
`endif
      check("sat_ovf_set", 32'(ovf), 32'({exp_ovf, 3'b000}));
      ovf_clr = 4'b1000;
      idle(1);
      ovf_clr = '0;
      idle(1);
      check("sat_ovf_cleared", 32'(ovf), 32'd0);
      grants[3] = 0;
      out_ready = 1'b1;
      wait_drain(40, ok);
      check("sat_drained", 32'(ok), 32'd1);
      check("sat_transfers", 32'(grants[3]), 32'(CNT_MAX));

      // Reset while an offer is held.
      out_ready = 1'b0;
      pulse(4'b0010);
      wait_valid(12, at, ok);
      check("rstmid_seen", 32'(ok), 32'd1);
      #2;
      areset = 1'b1;
      tgl_in = '0;
      #1;
      check("rstmid_async_drop", 32'(out_valid), 32'd0);
      clear_model();
      reset_release();
      out_ready = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) vcnt++;
      end
      check("rstmid_no_stale", 32'(vcnt), 32'd0);

      // Randomized toggles with random backpressure.
      for (int i = 0; i < 800; i++) begin
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(9) < 7);
         m = '0;
         for (int c = 0; c < CH_NUM; c++) begin
            if ($urandom_range(5) == 0 && exp_q[c].size() < CNT_MAX) m[c] = 1'b1;
         end
         apply(m);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_drain(200, ok);
      check("rand_drained", 32'(ok), 32'd1);
      check("rand_ovf", 32'(ovf), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
